// File: rtl/bp_me_wormhole_burst_rx_if.sv
// Wormhole burst receiver link bundle: upstream flit link, downstream header
// channel and downstream data-beat channel, all ready/valid.
// slave  : the receiver side (bp_me_wormhole_burst_rx)
// master : the environment side (link source plus header/data sinks)
interface bp_me_wormhole_burst_rx_if #(
  parameter int unsigned flit_width_p = 64
) ();

  // Upstream wormhole link
  logic [flit_width_p-1:0] link_data_i;
  logic                    link_v_i;
  logic                    link_ready_and_o;

  // Downstream header channel
  logic [flit_width_p-1:0] header_o;
  logic                    header_v_o;
  logic                    header_ready_and_i;

  // Downstream data-beat channel
  logic [flit_width_p-1:0] data_o;
  logic                    data_v_o;
  logic                    data_last_o;
  logic                    data_ready_and_i;

  modport slave (
    input  link_data_i,
    input  link_v_i,
    output link_ready_and_o,
    output header_o,
    output header_v_o,
    input  header_ready_and_i,
    output data_o,
    output data_v_o,
    output data_last_o,
    input  data_ready_and_i
  );

  modport master (
    output link_data_i,
    output link_v_i,
    input  link_ready_and_o,
    input  header_o,
    input  header_v_o,
    output header_ready_and_i,
    input  data_o,
    input  data_v_o,
    input  data_last_o,
    output data_ready_and_i
  );

endinterface

// File: rtl/bp_me_wormhole_burst_rx.sv
// Wormhole burst receiver: splits an incoming wormhole packet into one
// registered header and a zero-latency stream of data beats.
// Optional feature macro: BP_ME_WORMHOLE_RX_CORD_CHECK_EN
//   defined   -> headers whose cord field differs from my_cord_i are dropped
//                together with their body; drop_count_o counts such packets
//   undefined -> every header passes, drop_count_o does not exist
module bp_me_wormhole_burst_rx #(
  parameter int unsigned flit_width_p = 64,
  parameter int unsigned cord_width_p = 8,
  parameter int unsigned len_width_p  = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [cord_width_p-1:0] my_cord_i,
`ifdef BP_ME_WORMHOLE_RX_CORD_CHECK_EN
  output logic [15:0]             drop_count_o,
`endif
  bp_me_wormhole_burst_rx_if.slave link
);

  localparam int unsigned drop_width_lp = 16;

  typedef enum logic [1:0] {
    e_ready  = 2'd0,
    e_header = 2'd1,
    e_data   = 2'd2,
    e_drop   = 2'd3
  } state_e;

  state_e                  state_r, state_n;
  logic [flit_width_p-1:0] header_r;
  logic [len_width_p-1:0]  count_r;
  logic [len_width_p-1:0]  len_c;
  logic                    cord_ok_c;
  logic                    load_c;
  logic                    dec_c;
  logic                    drop_c;

  // Length field of the flit currently on the link
  assign len_c = link.link_data_i[cord_width_p +: len_width_p];

`ifdef BP_ME_WORMHOLE_RX_CORD_CHECK_EN
  // Destination check against the local coordinate
  assign cord_ok_c = (link.link_data_i[cord_width_p-1:0] == my_cord_i);
`else
  logic unused_c;

  // Without the check every header is accepted; the coordinate is not needed
  assign cord_ok_c = 1'b1;
  assign unused_c  = ^{my_cord_i, drop_c};
`endif

  // Header is always the registered flit; data beats pass straight through
  assign link.header_o = header_r;
  assign link.data_o   = link.link_data_i;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_ready;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_n                = state_r;
    link.link_ready_and_o  = 1'b0;
    link.header_v_o        = 1'b0;
    link.data_v_o          = 1'b0;
    link.data_last_o       = 1'b0;
    load_c                 = 1'b0;
    dec_c                  = 1'b0;
    drop_c                 = 1'b0;

    case (state_r)
      e_ready: begin
        // Ready is held low while reset is applied
        link.link_ready_and_o = ~reset_i;
        if (link.link_v_i && !reset_i) begin
          load_c = 1'b1;
          if (!cord_ok_c) begin
            drop_c = 1'b1;
            if (len_c != len_width_p'(0)) begin
              state_n = e_drop;
            end
          end else begin
            state_n = e_header;
          end
        end
      end

      e_header: begin
        link.header_v_o = 1'b1;
        if (link.header_ready_and_i) begin
          state_n = (count_r == len_width_p'(0)) ? e_ready : e_data;
        end
      end

      e_data: begin
        link.link_ready_and_o = link.data_ready_and_i;
        link.data_v_o         = link.link_v_i;
        link.data_last_o      = (count_r == len_width_p'(1));
        if (link.link_v_i && link.data_ready_and_i) begin
          dec_c = 1'b1;
          if (count_r == len_width_p'(1)) begin
            state_n = e_ready;
          end
        end
      end

      e_drop: begin
        link.link_ready_and_o = 1'b1;
        if (link.link_v_i) begin
          dec_c = 1'b1;
          if (count_r == len_width_p'(1)) begin
            state_n = e_ready;
          end
        end
      end

      default: begin
        state_n = e_ready;
      end
    endcase
  end

  // Header capture and remaining-flit counter; counter is never below 1
  // while decrementing, so it cannot wrap
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      header_r <= '0;
      count_r  <= '0;
    end else if (load_c) begin
      header_r <= link.link_data_i;
      count_r  <= len_c;
    end else if (dec_c) begin
      count_r  <= count_r - len_width_p'(1);
    end
  end

`ifdef BP_ME_WORMHOLE_RX_CORD_CHECK_EN
  logic [drop_width_lp-1:0] drop_count_r;

  // Saturating count of dropped packets
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_count_r <= '0;
    end else if (drop_c && (drop_count_r != {drop_width_lp{1'b1}})) begin
      drop_count_r <= drop_count_r + drop_width_lp'(1);
    end
  end

  assign drop_count_o = drop_count_r;
`endif

endmodule

// File: tb/tb_bp_me_wormhole_burst_rx.sv
// Bench for bp_me_wormhole_burst_rx: a packet-level model (queues of expected
// headers and beats) checked every cycle, plus literal checks per scenario.
module tb_bp_me_wormhole_burst_rx;

  localparam int unsigned FW = 64;
  localparam int unsigned CW = 8;
  localparam int unsigned LW = 4;
  localparam logic [7:0]  MY_CORD = 8'h35;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_me_wormhole_burst_rx_if #(.flit_width_p(FW)) lnk ();

`ifdef BP_ME_WORMHOLE_RX_CORD_CHECK_EN
  logic [15:0] drop_count;
`endif

  bp_me_wormhole_burst_rx #(
    .flit_width_p(FW),
    .cord_width_p(CW),
    .len_width_p (LW)
  ) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .my_cord_i   (MY_CORD),
`ifdef BP_ME_WORMHOLE_RX_CORD_CHECK_EN
    .drop_count_o(drop_count),
`endif
    .link        (lnk)
  );

  typedef struct {
    logic [63:0] d;
    logic        last;
  } beat_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_hdr[$];
  beat_t       exp_beat[$];
  int          exp_drops = 0;

  int          hdrs_seen = 0;
  int          beats_seen = 0;
  logic [63:0] last_beat_d = '0;
  logic        last_beat_last = 1'b0;
  logic        tog = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not allowed by model (t=%0t)", name, $time);
  endtask

  // Per-cycle comparison against the packet model
  always @(negedge clk) begin
    if (!rst) begin
      if (lnk.header_v_o) begin
        check("data_last_in_header", 64'(lnk.data_last_o), 64'd0);
        if (lnk.header_ready_and_i) begin
          if (exp_hdr.size() == 0) note_fail("unexpected_header");
          else begin
            check("header_o", lnk.header_o, exp_hdr.pop_front());
            hdrs_seen++;
          end
        end
      end
      if (lnk.data_v_o) begin
        check("ready_mirror", 64'(lnk.link_ready_and_o), 64'(lnk.data_ready_and_i));
        if (exp_beat.size() == 0) note_fail("unexpected_beat");
        else begin
          check("data_o", lnk.data_o, exp_beat[0].d);
          if (lnk.data_ready_and_i) begin
            check("data_last_o", 64'(lnk.data_last_o), 64'(exp_beat[0].last));
            last_beat_d    = lnk.data_o;
            last_beat_last = lnk.data_last_o;
            beats_seen++;
            void'(exp_beat.pop_front());
          end
        end
      end
    end
  end

  // Optional 1/0 toggling of data_ready_and_i
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog) lnk.data_ready_and_i = ~lnk.data_ready_and_i;
    end
  end

  // Offer one flit on the link until it is accepted
  task automatic send(input logic [63:0] f);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    lnk.link_v_i    = 1'b1;
    lnk.link_data_i = f;
    while (!done) begin
      @(negedge clk);
      if (lnk.link_ready_and_o) done = 1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        note_fail("link_accept_timeout");
        done = 1;
      end
    end
    lnk.link_v_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_hdr.size() != 0 || exp_beat.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) note_fail("drain_timeout");
  endtask

  function automatic logic [63:0] mk_hdr(input logic [51:0] tag, input logic [7:0] cord, input int len);
    return {tag, 4'(len), cord};
  endfunction

  function automatic bit cord_passes(input logic [7:0] cord);
`ifdef BP_ME_WORMHOLE_RX_CORD_CHECK_EN
    return cord == MY_CORD;
`else
    return (cord == cord) ? 1'b1 : 1'b1;
`endif
  endfunction

  // Send one packet and record what the model says must come out
  task automatic send_pkt(input logic [51:0] tag, input logic [7:0] cord, input int len,
                          input logic [63:0] base);
    logic [63:0] h;
    bit          pass;
    h    = mk_hdr(tag, cord, len);
    pass = cord_passes(cord);
    if (pass) begin
      exp_hdr.push_back(h);
      for (int i = 0; i < len; i++) exp_beat.push_back('{base + 64'(i), (i == len - 1)});
    end else begin
      exp_drops++;
    end
    send(h);
    check("header_latency", 64'(lnk.header_v_o), 64'(pass));
    for (int i = 0; i < len; i++) send(base + 64'(i));
    drain();
`ifdef BP_ME_WORMHOLE_RX_CORD_CHECK_EN
    check("drop_count_o", 64'(drop_count), 64'(exp_drops));
`endif
  endtask

  initial begin
    lnk.link_v_i           = 1'b0;
    lnk.link_data_i        = '0;
    lnk.header_ready_and_i = 1'b1;
    lnk.data_ready_and_i   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_link_ready", 64'(lnk.link_ready_and_o), 64'd0);
    check("rst_header_v", 64'(lnk.header_v_o), 64'd0);
    check("rst_data_v", 64'(lnk.data_v_o), 64'd0);
    check("rst_data_last", 64'(lnk.data_last_o), 64'd0);
    check("rst_header_o", lnk.header_o, 64'd0);
`ifdef BP_ME_WORMHOLE_RX_CORD_CHECK_EN
    check("rst_drop_count", 64'(drop_count), 64'd0);
`endif
    rst = 1'b0;
    #1;
    check("idle_link_ready", 64'(lnk.link_ready_and_o), 64'd1);

    // Header only
    send_pkt(52'h1, MY_CORD, 0, 64'd0);
    check("hdr_only_headers", 64'(hdrs_seen), 64'd1);
    check("hdr_only_beats", 64'(beats_seen), 64'd0);

    // Three beats A, B, C
    send_pkt(52'h2, MY_CORD, 3, 64'hA0A0_0000_0000_0000);
    check("len3_beats", 64'(beats_seen), 64'd3);
    check("len3_last_data", last_beat_d, 64'hA0A0_0000_0000_0002);
    check("len3_last_flag", 64'(last_beat_last), 64'd1);

    // Fifteen beats under toggling data ready
    tog = 1'b1;
    send_pkt(52'h3, MY_CORD, 15, 64'h1500_0000_0000_0000);
    tog = 1'b0;
    @(posedge clk);
    #2;
    lnk.data_ready_and_i = 1'b1;
    check("len15_beats", 64'(beats_seen), 64'd18);
    check("len15_last_data", last_beat_d, 64'h1500_0000_0000_000E);
    check("len15_last_flag", 64'(last_beat_last), 64'd1);

    // Header back-pressure for 20 cycles
    lnk.header_ready_and_i = 1'b0;
    exp_hdr.push_back(64'h0DEADBEEFCAFE035);
    send(64'h0DEADBEEFCAFE035);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_header_v", 64'(lnk.header_v_o), 64'd1);
      check("bp_link_ready", 64'(lnk.link_ready_and_o), 64'd0);
      check("bp_header_o", lnk.header_o, 64'h0DEADBEEFCAFE035);
    end
    @(posedge clk);
    #1;
    lnk.header_ready_and_i = 1'b1;
    drain();
    check("bp_headers", 64'(hdrs_seen), 64'd4);

    // Foreign coordinate (dropped with the check, delivered without it)
    send_pkt(52'h4, MY_CORD + 8'd1, 2, 64'hD000_0000_0000_0000);
    send_pkt(52'h5, MY_CORD + 8'd2, 0, 64'd0);
    send_pkt(52'h6, MY_CORD, 1, 64'h6000_0000_0000_0000);
    check("after_drop_last", last_beat_d, 64'h6000_0000_0000_0000);

    // Reset in the middle of a len=4 packet
    exp_hdr.push_back(mk_hdr(52'h7, MY_CORD, 4));
    for (int i = 0; i < 4; i++) exp_beat.push_back('{64'h7000_0000_0000_0000 + 64'(i), (i == 3)});
    send(mk_hdr(52'h7, MY_CORD, 4));
    send(64'h7000_0000_0000_0000);
    rst = 1'b1;
    #1;
    check("midrst_header_v", 64'(lnk.header_v_o), 64'd0);
    check("midrst_data_v", 64'(lnk.data_v_o), 64'd0);
    check("midrst_data_last", 64'(lnk.data_last_o), 64'd0);
    check("midrst_link_ready", 64'(lnk.link_ready_and_o), 64'd0);
    exp_beat.delete();
    exp_drops = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_pkt(52'h8, MY_CORD, 0, 64'd0);
    check("post_rst_header", lnk.header_o, 64'h0000_0000_0000_8035);

    check("queues_empty", 64'(exp_hdr.size() + exp_beat.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bp_me_wormhole_burst_rx.md
BP_ME_WORMHOLE_BURST_RX -- requirements
Module: bp_me_wormhole_burst_rx

Interface
REQ-001 SHALL have parameter flit_width_p, default 64, meaning the width in bits of each wormhole flit and of each data beat.
REQ-002 SHALL have parameter cord_width_p, default 8, meaning the destination coordinate field at header bits [cord_width_p-1:0].
REQ-003 SHALL have parameter len_width_p, default 4, meaning the length field at header bits [cord_width_p+:len_width_p], which counts the flits that follow the header.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock for the block.
REQ-005 SHALL have port reset_i, input, 1 bit, an asynchronous active-high reset.
REQ-006 SHALL have port my_cord_i, input, cord_width_p bits, the local coordinate, stable while out of reset.
REQ-007 SHALL have ports link_data_i (flit_width_p), link_v_i (1) and link_ready_and_o (1), the upstream ready/valid wormhole link driven by the tile-node mem socket.
REQ-008 SHALL have ports header_o (flit_width_p), header_v_o (1) and header_ready_and_i (1), the downstream header channel.
REQ-009 SHALL have ports data_o (flit_width_p), data_v_o (1), data_last_o (1) and data_ready_and_i (1), the downstream data-beat channel.
REQ-010 SHALL have port drop_count_o, output, 16 bits, the saturating count of dropped packets; this port is present only when the macro in REQ-024 is defined.

Function
REQ-011 SHALL implement the states e_ready, e_header, e_data and e_drop.
REQ-012 e_ready: link_ready_and_o SHALL be 1; on link_v_i, the block SHALL capture the flit into the header register and load the counter with the len field.
REQ-013 From e_ready after capture, the block SHALL go to e_drop if the check in REQ-024 fails and len is nonzero, SHALL stay in e_ready if the check fails and len is 0, and SHALL go to e_header otherwise.
REQ-014 e_header: header_v_o SHALL be 1, header_o SHALL equal the registered flit, and link_ready_and_o SHALL be 0; a header appears exactly 1 cycle after it is accepted.
REQ-015 e_header, on a header_ready_and_i handshake: the block SHALL go to e_ready if len is 0, else to e_data.
REQ-016 e_data: the path SHALL be combinational pass-through, with data_o=link_data_i, data_v_o=link_v_i and link_ready_and_o=data_ready_and_i, so beats see zero latency.
REQ-017 In e_data, the counter SHALL decrement on each handshake, data_last_o SHALL equal (count==1), and the block SHALL go to e_ready after the last handshake.
REQ-018 e_drop: link_ready_and_o SHALL be 1 and header_v_o and data_v_o SHALL be 0; each accepted flit SHALL decrement the counter, and the block SHALL go to e_ready when count reaches 1 and that flit is accepted.
REQ-019 In e_ready, header_v_o and data_v_o SHALL be 0, and data_last_o SHALL be 0 outside e_data.
REQ-020 The counter SHALL be len_width_p bits wide, the maximum packet SHALL be 1 header plus 2^len_width_p-1 beats, and the counter SHALL never wrap.
REQ-021 Back-pressure: if header_ready_and_i or data_ready_and_i is held at 0, the block SHALL hold its state indefinitely with no flit lost or duplicated.

Reset
REQ-022 On assertion of reset_i, the block SHALL asynchronously enter e_ready and set the counter, header register and drop_count_o to 0; all valid outputs and data_last_o SHALL be 0, and link_ready_and_o SHALL be 0 while reset_i is high.
REQ-023 A reset arriving mid-packet SHALL abandon the packet, and the first flit accepted after deassertion SHALL be treated as a header.

Configuration
REQ-024 With BP_ME_WORMHOLE_RX_CORD_CHECK_EN defined, a header whose cord field differs from my_cord_i SHALL be dropped with its body, and drop_count_o SHALL increment by 1 per dropped packet, saturating at 16'hFFFF; without the macro, every header SHALL pass, the e_drop state SHALL be unreachable, and drop_count_o SHALL be absent.

Verification
REQ-025 Header with cord=my_cord, len=0, then header_ready_and_i=1 -> header_v_o is asserted 1 cycle after accept and the block returns to e_ready, with no data_v_o.
REQ-026 Header with len=3 followed by beats A, B, C with data_ready_and_i=1 -> data_o=A, B, C, with data_last_o set only on C, then e_ready.
REQ-027 len=15 with data_ready_and_i toggling 1,0 every cycle -> exactly 15 beats in order, data_last_o on the 15th, and link_ready_and_o mirroring data_ready_and_i.
REQ-028 CHECK_EN defined, header cord=my_cord+1, len=2 -> 3 flits are consumed, no header or data valid is asserted, and drop_count_o becomes 1; the next good packet is delivered normally.
REQ-029 reset_i asserted after beat 1 of a len=4 packet -> outputs clear immediately, and the next flit after release is emitted as header_o.
REQ-030 header_ready_and_i held at 0 for 20 cycles -> header_v_o is held, link_ready_and_o stays 0, and header_o is stable throughout.
